// File: rtl/sprite_mover_if.sv
// Sprite mover port bundle: pixel/frame controls in, committed sprite state and hit out.
interface sprite_mover_if;
   logic       frame_start;
   logic       enable;
   logic [9:0] pix_x;
   logic [9:0] pix_y;
   logic [9:0] pos_x;
   logic [9:0] pos_y;
   logic       pos_valid;
   logic       hit;
   logic [7:0] bounce_cnt;

   modport master (
      output frame_start, enable, pix_x, pix_y,
      input  pos_x, pos_y, pos_valid, hit, bounce_cnt
   );

   modport slave (
      input  frame_start, enable, pix_x, pix_y,
      output pos_x, pos_y, pos_valid, hit, bounce_cnt
   );
endinterface

// File: rtl/sprite_mover.sv
// Bouncing 16x16 sprite: position commits 2 cycles after frame_start, hit 1 cycle after pix; no backpressure, frame_start outside IDLE is dropped.
// Define SPRITE_MOVER_BITMAP_EN to mask the hit box with a circle-outline ROM.
module sprite_mover #(
   parameter int H_DISPLAY = 640,
   parameter int V_DISPLAY = 480,
   parameter int SPR_SIZE  = 16,
   parameter int STEP      = 2,
   parameter int FRAME_DIV = 1
) (
   input  logic          CLK,
   input  logic          RST,
   sprite_mover_if.slave bus
);
   localparam logic [10:0] MAX_X    = 11'(H_DISPLAY - SPR_SIZE);
   localparam logic [10:0] MAX_Y    = 11'(V_DISPLAY - SPR_SIZE);
   localparam logic [10:0] STP      = 11'(STEP);
   localparam logic [7:0]  DIV_LAST = 8'(FRAME_DIV - 1);
   localparam logic [9:0]  SPR      = 10'(SPR_SIZE);

   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, COMMIT = 2'd2} state_t;

   state_t     state, state_nxt;
   logic       div_clr, div_inc, calc_en, commit_en;
   logic [7:0] div_q;
   logic [9:0] pos_x_q, pos_y_q, calc_x, calc_y, step_x, step_y;
   logic       dir_x, dir_y, calc_dir_x, calc_dir_y, step_dir_x, step_dir_y;
   logic       bnc_x, bnc_y, calc_bnc;
   logic       pos_valid_q, hit_q, hit_nxt, base_hit;
   logic [7:0] bnc_cnt_q;
   logic [9:0] dx, dy;

   // Returns {bounce, new_dir, new_pos}; dir 0 means moving toward larger coordinates.
   function automatic logic [11:0] axis_step(input logic [9:0] pos, input logic dir,
                                             input logic [10:0] max);
      logic [11:0] r;
      if (!dir) begin
         if ({1'b0, pos} + STP >= max) r = {1'b1, 1'b1, max[9:0]};
         else                          r = {1'b0, 1'b0, pos + STP[9:0]};
      end else begin
         if ({1'b0, pos} <= STP) r = {1'b1, 1'b0, 10'd0};
         else                    r = {1'b0, 1'b1, pos - STP[9:0]};
      end
      return r;
   endfunction

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      div_clr   = 1'b0;
      div_inc   = 1'b0;
      calc_en   = 1'b0;
      commit_en = 1'b0;
      case (state)
         IDLE: begin
            if (bus.frame_start && bus.enable) begin
               if (div_q == DIV_LAST) begin
                  div_clr   = 1'b1;
                  state_nxt = CALC;
               end else begin
                  div_inc = 1'b1;
               end
            end
         end
         CALC: begin
            calc_en   = 1'b1;
            state_nxt = COMMIT;
         end
         COMMIT: begin
            commit_en = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      {bnc_x, step_dir_x, step_x} = axis_step(pos_x_q, dir_x, MAX_X);
      {bnc_y, step_dir_y, step_y} = axis_step(pos_y_q, dir_y, MAX_Y);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         div_q       <= 8'd0;
         calc_x      <= 10'd0;
         calc_y      <= 10'd0;
         calc_dir_x  <= 1'b0;
         calc_dir_y  <= 1'b0;
         calc_bnc    <= 1'b0;
         pos_x_q     <= 10'd0;
         pos_y_q     <= 10'd0;
         dir_x       <= 1'b0;
         dir_y       <= 1'b0;
         bnc_cnt_q   <= 8'd0;
         pos_valid_q <= 1'b0;
      end else begin
         if (div_clr)      div_q <= 8'd0;
         else if (div_inc) div_q <= div_q + 8'd1;
         if (calc_en) begin
            calc_x     <= step_x;
            calc_y     <= step_y;
            calc_dir_x <= step_dir_x;
            calc_dir_y <= step_dir_y;
            calc_bnc   <= bnc_x | bnc_y;
         end
         pos_valid_q <= commit_en;
         if (commit_en) begin
            pos_x_q <= calc_x;
            pos_y_q <= calc_y;
            dir_x   <= calc_dir_x;
            dir_y   <= calc_dir_y;
            // A corner bounce on both axes still counts as one event.
            if (calc_bnc && bnc_cnt_q != 8'hFF) bnc_cnt_q <= bnc_cnt_q + 8'd1;
         end
      end
   end

`ifdef SPRITE_MOVER_BITMAP_EN
   localparam logic [255:0] SPRITE_ROM = {
      16'h07E0, 16'h1818, 16'h2004, 16'h4002, 16'h4002, 16'h8001, 16'h8001, 16'h8001,
      16'h8001, 16'h8001, 16'h8001, 16'h4002, 16'h4002, 16'h2004, 16'h1818, 16'h07E0
   };
   logic [7:0] rom_idx;
`endif

   always_comb begin
      // Pixels left of or above the sprite wrap to large values and miss.
      dx       = bus.pix_x - pos_x_q;
      dy       = bus.pix_y - pos_y_q;
      base_hit = (dx < SPR) && (dy < SPR);
`ifdef SPRITE_MOVER_BITMAP_EN
      rom_idx  = 8'd255 - {dy[3:0], dx[3:0]};
      hit_nxt  = base_hit & SPRITE_ROM[rom_idx];
`else
      hit_nxt  = base_hit;
`endif
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) hit_q <= 1'b0;
      else     hit_q <= hit_nxt;
   end

   assign bus.pos_x      = pos_x_q;
   assign bus.pos_y      = pos_y_q;
   assign bus.pos_valid  = pos_valid_q;
   assign bus.hit        = hit_q;
   assign bus.bounce_cnt = bnc_cnt_q;
endmodule

// File: tb/tb_sprite_mover.sv
// Scoreboard bench: stimulus queues expected commits/hits, a negedge monitor pops and compares.
module tb_sprite_mover;
   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   sprite_mover_if b0 ();
   sprite_mover_if b1 ();
   sprite_mover_if b2 ();

   sprite_mover u0 (.CLK(CLK), .RST(RST), .bus(b0));
   sprite_mover #(.H_DISPLAY(480), .V_DISPLAY(480)) u1 (.CLK(CLK), .RST(RST), .bus(b1));
   sprite_mover #(.FRAME_DIV(3)) u2 (.CLK(CLK), .RST(RST), .bus(b2));

   typedef struct {
      int id;
      int x;
      int y;
      int b;
      int cyc;
   } exp_t;

   exp_t pq[$];
   int   hq[$];
   logic hit_req = 1'b0;
   logic hit_pend;

   logic [2:0] pv;
   logic [9:0] px[3];
   logic [9:0] py[3];
   logic [7:0] pb[3];
   assign pv    = {b2.pos_valid, b1.pos_valid, b0.pos_valid};
   assign px[0] = b0.pos_x;  assign py[0] = b0.pos_y;  assign pb[0] = b0.bounce_cnt;
   assign px[1] = b1.pos_x;  assign py[1] = b1.pos_y;  assign pb[1] = b1.bounce_cnt;
   assign px[2] = b2.pos_x;  assign py[2] = b2.pos_y;  assign pb[2] = b2.bounce_cnt;

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: every pos_valid pulse must match the oldest queued commit.
   always @(posedge CLK) hit_pend <= hit_req;

   always @(negedge CLK) begin
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         if (pv[i]) begin
            if (pq.size() == 0) begin
               chk($sformatf("d%0d_unexpected_pos_valid", i), 1, 0);
            end else begin
               e = pq.pop_front();
               chk("pos_valid_dut", i, e.id);
               chk($sformatf("d%0d_commit_cycle", i), cyc, e.cyc);
               chk($sformatf("d%0d_pos_x", i), int'(px[i]), e.x);
               chk($sformatf("d%0d_pos_y", i), int'(py[i]), e.y);
               chk($sformatf("d%0d_bounce_cnt", i), int'(pb[i]), e.b);
            end
         end
      end
      if (hit_pend) begin
         if (hq.size() == 0) chk("hit_unexpected_sample", 1, 0);
         else                chk($sformatf("hit_at_%0d_%0d", b0.pix_x, b0.pix_y), int'(b0.hit), hq.pop_front());
      end
   end

   task automatic set_fs(input int id, input logic v);
      case (id)
         0:       b0.frame_start = v;
         1:       b1.frame_start = v;
         default: b2.frame_start = v;
      endcase
   endtask

   // One frame_start pulse; if push, the commit is expected after edge N+2.
   task automatic pulse(input int id, input bit push, input int ex, input int ey, input int eb);
      exp_t e;
      @(negedge CLK);
      set_fs(id, 1'b1);
      if (push) begin
         e = '{id: id, x: ex, y: ey, b: eb, cyc: cyc + 3};
         pq.push_back(e);
      end
      @(negedge CLK);
      set_fs(id, 1'b0);
   endtask

   task automatic step(input int id, input bit push, input int ex, input int ey, input int eb);
      pulse(id, push, ex, ey, eb);
      repeat (3) @(negedge CLK);
   endtask

   task automatic probe(input int x, input int y, input int exp_box, input int exp_bm);
      @(negedge CLK);
      b0.pix_x = 10'(x);
      b0.pix_y = 10'(y);
      hit_req  = 1'b1;
`ifdef SPRITE_MOVER_BITMAP_EN
      hq.push_back(exp_bm);
`else
      hq.push_back(exp_box);
`endif
   endtask

   // Closed-form positions for STEP=2 starting at (0,0), both directions +.
   function automatic int fx(input int k);
      return (k <= 312) ? 2 * k : 624 - 2 * (k - 312);
   endfunction
   function automatic int fy(input int k);
      return (k <= 232) ? 2 * k : 464 - 2 * (k - 232);
   endfunction
   function automatic int fb(input int k);
      return int'(k >= 232) + int'(k >= 312);
   endfunction

   initial begin
      b0.frame_start = 0; b0.enable = 1; b0.pix_x = 10'd500; b0.pix_y = 10'd400;
      b1.frame_start = 0; b1.enable = 1; b1.pix_x = 10'd0;   b1.pix_y = 10'd0;
      b2.frame_start = 0; b2.enable = 1; b2.pix_x = 10'd0;   b2.pix_y = 10'd0;
      repeat (3) @(negedge CLK);
      chk("rst_pos_x", int'(b0.pos_x), 0);
      chk("rst_pos_y", int'(b0.pos_y), 0);
      chk("rst_pos_valid", int'(b0.pos_valid), 0);
      chk("rst_hit", int'(b0.hit), 0);
      chk("rst_bounce_cnt", int'(b0.bounce_cnt), 0);
      RST = 1'b0;

      // Reset while in CALC: no commit may survive.
      pulse(0, 0, 0, 0, 0);
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      chk("midcalc_pos_x", int'(b0.pos_x), 0);
      chk("midcalc_pos_valid", int'(b0.pos_valid), 0);
      RST = 1'b0;
      repeat (3) @(negedge CLK);
      chk("midcalc_after_pos_x", int'(b0.pos_x), 0);

      step(0, 1, 2, 2, 0);
      step(0, 1, 4, 4, 0);
      // Second frame_start lands in CALC and is dropped.
      @(negedge CLK);
      set_fs(0, 1'b1);
      pq.push_back('{id: 0, x: 6, y: 6, b: 0, cyc: cyc + 3});
      @(negedge CLK);
      @(negedge CLK);
      set_fs(0, 1'b0);
      repeat (4) @(negedge CLK);
      b0.enable = 1'b0;
      step(0, 0, 0, 0, 0);
      chk("disabled_pos_x", int'(b0.pos_x), 6);
      b0.enable = 1'b1;
      // Enable dropped during CALC must not abort the step.
      pulse(0, 1, 8, 8, 0);
      b0.enable = 1'b0;
      repeat (3) @(negedge CLK);
      b0.enable = 1'b1;

      for (int k = 5; k <= 315; k++) begin
         step(0, 1, fx(k), fy(k), fb(k));
         if (k == 50) begin
            probe(115, 100, 1, 0);
            probe(116, 100, 0, 0);
            probe(99, 100, 0, 0);
            probe(100, 115, 1, 0);
            probe(100, 116, 0, 0);
            probe(100, 99, 0, 0);
            probe(0, 0, 0, 0);
            probe(107, 107, 1, 0);
            probe(100, 100, 1, 0);
            probe(100, 107, 1, 1);
            probe(105, 100, 1, 1);
            @(negedge CLK);
            hit_req = 1'b0;
            repeat (2) @(negedge CLK);
         end
      end

      // Square field: both axes bounce on the same step, counted once.
      for (int k = 1; k <= 233; k++) step(1, 1, fy(k), fy(k), int'(k >= 232));

      // FRAME_DIV=3: commits on the 3rd and 6th pulse; divider freezes while disabled.
      for (int p = 1; p <= 6; p++) step(2, p % 3 == 0, 2 * (p / 3), 2 * (p / 3), 0);
      step(2, 0, 0, 0, 0);
      b2.enable = 1'b0;
      repeat (3) step(2, 0, 0, 0, 0);
      b2.enable = 1'b1;
      step(2, 0, 0, 0, 0);
      step(2, 1, 6, 6, 0);

      repeat (5) @(negedge CLK);
      chk("pos_queue_drained", pq.size(), 0);
      chk("hit_queue_drained", hq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end
endmodule
